// File: rtl/task_six_pkg.sv
// Shared types and constants for the registered two-digit BCD adder (task_six).
package task_six_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/task_six_bcd_digit_add.sv
// One BCD digit slice: a + b + cin, folded back into 0..9 with a decimal carry out.
module bcd_digit_add
  import task_six_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       cin_i,
  output bcd_digit_t digit_o,
  output logic       cout_o
);

  logic [4:0] sum_raw;
  logic [4:0] sum_adj;

  always_comb begin
    sum_raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    sum_adj = sum_raw - BCD_BASE;
    if (sum_raw >= BCD_BASE) begin
      digit_o = sum_adj[3:0];
      cout_o  = 1'b1;
    end else begin
      digit_o = sum_raw[3:0];
      cout_o  = 1'b0;
    end
  end

endmodule

// File: rtl/task_six.sv
// Registered two-digit BCD adder with one-cycle latency.
// Define TASK_SIX_ERR_EN to add the bcd_err port and invalid-digit squashing.
module task_six
  import task_six_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a_tens,
  input  logic [DIGIT_W-1:0] a_ones,
  input  logic [DIGIT_W-1:0] b_tens,
  input  logic [DIGIT_W-1:0] b_ones,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum_hund,
  output logic [DIGIT_W-1:0] sum_tens,
  output logic [DIGIT_W-1:0] sum_ones
`ifdef TASK_SIX_ERR_EN
  ,
  output logic               bcd_err
`endif
);

  // Handshake: in_valid qualifies the operand digits at a rising edge; out_valid
  // follows one cycle later. There is no backpressure, so every valid sample
  // produces exactly one result on the following cycle.

  bcd_digit_t ones_digit, tens_digit;
  logic       ones_cout, tens_cout;

  logic       valid_q, valid_d;
  bcd_digit_t hund_q, hund_d;
  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;

  bcd_digit_add u_ones (
    .a_i     (a_ones),
    .b_i     (b_ones),
    .cin_i   (1'b0),
    .digit_o (ones_digit),
    .cout_o  (ones_cout)
  );

  bcd_digit_add u_tens (
    .a_i     (a_tens),
    .b_i     (b_tens),
    .cin_i   (ones_cout),
    .digit_o (tens_digit),
    .cout_o  (tens_cout)
  );

`ifdef TASK_SIX_ERR_EN
  logic err_q, err_d;
  logic bad_digit;

  assign bad_digit = (a_tens > BCD_MAX) || (a_ones > BCD_MAX) ||
                     (b_tens > BCD_MAX) || (b_ones > BCD_MAX);
`endif

  always_comb begin
    valid_d = in_valid;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
`ifdef TASK_SIX_ERR_EN
    err_d   = err_q;
`endif
    if (in_valid) begin
      hund_d = {3'b000, tens_cout};
      tens_d = tens_digit;
      ones_d = ones_digit;
`ifdef TASK_SIX_ERR_EN
      // A sample with any non-BCD digit yields a zero result and raises the flag.
      err_d = bad_digit;
      if (bad_digit) begin
        hund_d = '0;
        tens_d = '0;
        ones_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
`ifdef TASK_SIX_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
`ifdef TASK_SIX_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign sum_hund  = hund_q;
  assign sum_tens  = tens_q;
  assign sum_ones  = ones_q;
`ifdef TASK_SIX_ERR_EN
  assign bcd_err   = err_q;
`endif

endmodule

// File: tb/tb_task_six.sv
// Bench for task_six: directed and randomized operands against a decimal reference model.
module tb_task_six;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a_tens = '0, a_ones = '0, b_tens = '0, b_ones = '0;
  logic       out_valid;
  logic [3:0] sum_hund, sum_tens, sum_ones;
`ifdef TASK_SIX_ERR_EN
  logic       bcd_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  // expected {err, hund, tens, ones}
  logic [12:0] exp_q[$];
  logic [12:0] cur_exp = '0;
  logic        exp_valid = 1'b0;

  task_six dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a_tens    (a_tens),
    .a_ones    (a_ones),
    .b_tens    (b_tens),
    .b_ones    (b_ones),
    .out_valid (out_valid),
    .sum_hund  (sum_hund),
    .sum_tens  (sum_tens),
    .sum_ones  (sum_ones)
`ifdef TASK_SIX_ERR_EN
    ,
    .bcd_err   (bcd_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ref_sum(input logic [3:0] at, ao, bt, bo);
    int n, s, c_lo, c_hi, d_lo, d_hi;
    if (at <= 9 && ao <= 9 && bt <= 9 && bo <= 9) begin
      n = 10 * int'(at) + int'(ao) + 10 * int'(bt) + int'(bo);
      return {1'b0, 4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    end
`ifdef TASK_SIX_ERR_EN
    return {1'b1, 12'h000};
`else
    s    = int'(ao) + int'(bo);
    c_lo = (s >= 10) ? 1 : 0;
    d_lo = (s >= 10) ? (s - 10) % 16 : s;
    s    = int'(at) + int'(bt) + c_lo;
    c_hi = (s >= 10) ? 1 : 0;
    d_hi = (s >= 10) ? (s - 10) % 16 : s;
    return {1'b0, 4'(c_hi), 4'(d_hi), 4'(d_lo)};
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    check({tag, "_valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
    check({tag, "_sum"}, {4'd0, sum_hund, sum_tens, sum_ones}, {4'd0, cur_exp[11:0]});
`ifdef TASK_SIX_ERR_EN
    check({tag, "_err"}, {15'd0, bcd_err}, {15'd0, cur_exp[12]});
`endif
  endtask

  task automatic drive(input string tag, input logic v, input logic [3:0] at, ao, bt, bo);
    @(negedge clk);
    in_valid = v;
    a_tens   = at;
    a_ones   = ao;
    b_tens   = bt;
    b_ones   = bo;
    n_vec++;
    if (v) exp_q.push_back(ref_sum(at, ao, bt, bo));
    @(posedge clk);
    exp_valid = v;
    #1;
    check_outputs(tag);
  endtask

  task automatic drive_dec(input string tag, input int a, input int b);
    drive(tag, 1'b1, 4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10));
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // directed values and boundaries
    drive_dec("a77_b64", 77, 64);
    drive_dec("a76_b55", 76, 55);
    drive_dec("a43_b99", 43, 99);
    drive_dec("a99_b96", 99, 96);
    drive_dec("a00_b00", 0, 0);
    drive_dec("a99_b99", 99, 99);
    drive_dec("a50_b50", 50, 50);
    drive_dec("a09_b01", 9, 1);

    // gap: out_valid drops, sums hold
    drive("gap0", 1'b0, 4'd3, 4'd3, 4'd3, 4'd3);
    drive("gap1", 1'b0, 4'd7, 4'd1, 4'd2, 4'd5);

    // invalid digit, then a clean sample
    drive("bad_a", 1'b1, 4'hA, 4'd0, 4'd1, 4'd1);
    drive_dec("a12_b34", 12, 34);

    // streaming back-to-back
    drive_dec("strm0", 18, 27);
    drive_dec("strm1", 65, 35);
    drive_dec("strm2", 1, 98);
    drive_dec("strm3", 44, 56);

    // reset asserted between edges
    drive_dec("pre_rst", 88, 88);
    @(negedge clk);
    in_valid = 1'b1;
    a_tens = 4'd5; a_ones = 4'd5; b_tens = 4'd5; b_ones = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    cur_exp   = '0;
    exp_valid = 1'b0;
    check_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    drive("post_rst_idle", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    drive_dec("post_rst", 37, 46);

    // randomized BCD operands with random valid gaps
    for (int i = 0; i < 60; i++) begin
      drive("rand_bcd", ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    end

    // randomized raw digits, including non-BCD codes
    for (int i = 0; i < 20; i++) begin
      drive("rand_raw", 1'b1,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    drive("tail", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
